// File: rtl/fmul_arb_pkg.sv
// Shared float format, tag type and helpers for the float multiplier arbiter.
package fmul_arb_pkg;

  localparam int EXP_W    = 7;
  localparam int MAN_W    = 16;
  localparam int FLOAT_W  = 1 + EXP_W + MAN_W;
  localparam int MAX_ID_W = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fmul_arb_fifo.sv
// Synchronous response FIFO; head reads as zero while empty so outputs stay clean.
module fmul_arb_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one fixed-latency float multiplier with credit-protected responses.
// Optional stall counter (stall_cnt/stall_clr) is built when FMUL_ARB_PERF_EN is defined.
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int MUL_LATENCY = 3,
  parameter  int FIFO_DEPTH  = 4,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FLOAT_W-1:0] req_a,
  input  logic [NUM_REQ*FLOAT_W-1:0] req_b,
  output logic [FLOAT_W-1:0]         mul_a,
  output logic [FLOAT_W-1:0]         mul_b,
  input  logic [FLOAT_W-1:0]         mul_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [FLOAT_W-1:0]         resp_data,
  output logic [ID_W-1:0]            resp_id
`ifdef FMUL_ARB_PERF_EN
  ,
  input  logic                       stall_clr,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int LAST = MUL_LATENCY;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W:0]      cand;
  logic               found;
  logic               credit_ok;
  logic               issue;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        used;
  logic [FLOAT_W-1:0] op_a [NUM_REQ];
  logic [FLOAT_W-1:0] op_b [NUM_REQ];
  tag_t               tag_in;
  tag_t               tag_p [MUL_LATENCY+1];
  logic [FLOAT_W+ID_W-1:0] push_data;
  logic [FLOAT_W+ID_W-1:0] head;
  logic               unused_tag_bits;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = req_a[i*FLOAT_W +: FLOAT_W];
      op_b[i] = req_b[i*FLOAT_W +: FLOAT_W];
    end
  end

  assign used      = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok = (used < (CW+1)'(FIFO_DEPTH));

  // Search starts one past the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[ID_W-1:0];
      end
    end
  end

  assign issue     = found & credit_ok & rst;
  assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    tag_in              = '0;
    tag_in.valid        = issue;
    tag_in.id[ID_W-1:0] = grant_id;
  end

  // Stage 0: operand registers and tag entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a <= '0;
      mul_b <= '0;
      ptr   <= ID_W'(NUM_REQ - 1);
    end else if (issue) begin
      mul_a <= op_a[grant_id];
      mul_b <= op_b[grant_id];
      ptr   <= grant_id;
    end
  end

  // Stages 1..MUL_LATENCY: tag travels alongside the external datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LAST; i++) tag_p[i] <= '0;
      inflight <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i <= LAST; i++) tag_p[i] <= tag_p[i-1];
      inflight <= inflight + CW'(issue) - CW'(tag_p[LAST].valid);
    end
  end

  assign unused_tag_bits = ^tag_p[LAST].id;
  assign push_data       = {mul_result, tag_p[LAST].id[ID_W-1:0]};

  // Response stage: result and id captured when the final tag is valid
  fmul_arb_fifo #(
    .WIDTH (FLOAT_W + ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_p[LAST].valid),
    .push_data (push_data),
    .pop       (resp_ready),
    .valid     (resp_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign resp_data = head[FLOAT_W+ID_W-1:ID_W];
  assign resp_id   = head[ID_W-1:0];

`ifdef FMUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (|req_valid && !credit_ok && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
